// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the MIPS-subset CPU.
// Fetches over a req/ack handshake, decodes the opcode into an ALUOp class,
// then runs EXEC/WB or BRANCH. Counts retired instructions and parks in a
// terminal ILLEGAL state on unknown opcodes.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,       // active low, asynchronous
  input  logic [5:0]       opcode_i,
  input  logic             imem_ack_i,
  input  logic             zero_i,
  output logic             imem_req_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic [2:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExec    = 3'd2,
    StWb      = 3'd3,
    StBranch  = 3'd4,
    StIllegal = 3'd5
  } state_e;

  // Opcode class doubles as the ALUOp value driven to ALU control.
  localparam logic [2:0] ClsR     = 3'd0;
  localparam logic [2:0] ClsAddi  = 3'd1;
  localparam logic [2:0] ClsSltiu = 3'd2;
  localparam logic [2:0] ClsBeq   = 3'd3;
  localparam logic [2:0] ClsLui   = 3'd4;
  localparam logic [2:0] ClsOri   = 3'd5;
  localparam logic [2:0] ClsBne   = 3'd6;

  state_e           state_q;
  logic [2:0]       cls_q;
  logic [CNT_W-1:0] retired_q;

  logic       dec_valid;
  logic       dec_branch;
  logic [2:0] dec_cls;
  logic       taken;

  // Opcode decode; only consumed while in DECODE.
  always_comb begin
    dec_valid  = 1'b1;
    dec_branch = 1'b0;
    dec_cls    = ClsR;
    case (opcode_i)
      6'b000000: dec_cls = ClsR;
      6'b001000: dec_cls = ClsAddi;
      6'b001011: dec_cls = ClsSltiu;
      6'b001111: dec_cls = ClsLui;
      6'b001101: dec_cls = ClsOri;
      6'b000100: begin
        dec_cls    = ClsBeq;
        dec_branch = 1'b1;
      end
      6'b000101: begin
        dec_cls    = ClsBne;
        dec_branch = 1'b1;
      end
      default:   dec_valid = 1'b0;
    endcase
  end

  // State sequencing, opcode class latch and retired-instruction counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      retired_q <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_ack_i) state_q <= StDecode;
        end
        StDecode: begin
          cls_q <= dec_cls;
          if (!dec_valid)      state_q <= StIllegal;
          else if (dec_branch) state_q <= StBranch;
          else                 state_q <= StExec;
        end
        StExec: state_q <= StWb;
        StWb, StBranch: begin
          retired_q <= retired_q + CNT_W'(1);
          state_q   <= StFetch;
        end
        StIllegal: state_q <= StIllegal;
        default:   state_q <= StFetch;
      endcase
    end
  end

  assign taken = (cls_q == ClsBne) ? !zero_i : zero_i;

  // Output decode; everything forced low while reset is held.
  always_comb begin
    imem_req_o = 1'b0;
    ir_write_o = 1'b0;
    pc_write_o = 1'b0;
    pc_src_o   = 1'b0;
    ALUOp_o    = 3'd0;
    ALUSrc_o   = 1'b0;
    RegDst_o   = 1'b0;
    RegWrite_o = 1'b0;
    illegal_o  = 1'b0;
    retired_o  = '0;
    if (rst_i) begin
      retired_o = retired_q;
      case (state_q)
        StFetch: begin
          imem_req_o = 1'b1;
          ir_write_o = imem_ack_i;
          pc_write_o = imem_ack_i;
        end
        StExec, StWb: begin
          ALUOp_o    = cls_q;
          ALUSrc_o   = (cls_q != ClsR);
          RegDst_o   = (cls_q == ClsR);
          RegWrite_o = (state_q == StWb);
        end
        StBranch: begin
          ALUOp_o    = cls_q;
          pc_write_o = taken;
          pc_src_o   = taken;
        end
        StIllegal: illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table-driven instruction vectors,
// hand-written reset/illegal/wrap sequences and randomized instruction streams.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       ack;
  logic       zero;

  logic        req, irw, pcw, pcs, src, dst, rw, ill;
  logic [2:0]  alu;
  logic [31:0] retired;

  logic        q_req, q_irw, q_pcw, q_pcs, q_src, q_dst, q_rw, q_ill;
  logic [2:0]  q_alu;
  logic [3:0]  q_retired;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned model_ret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .opcode_i(opcode), .imem_ack_i(ack), .zero_i(zero),
    .imem_req_o(req), .ir_write_o(irw), .pc_write_o(pcw), .pc_src_o(pcs),
    .ALUOp_o(alu), .ALUSrc_o(src), .RegDst_o(dst), .RegWrite_o(rw),
    .illegal_o(ill), .retired_o(retired)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .opcode_i(opcode), .imem_ack_i(ack), .zero_i(zero),
    .imem_req_o(q_req), .ir_write_o(q_irw), .pc_write_o(q_pcw), .pc_src_o(q_pcs),
    .ALUOp_o(q_alu), .ALUSrc_o(q_src), .RegDst_o(q_dst), .RegWrite_o(q_rw),
    .illegal_o(q_ill), .retired_o(q_retired)
  );

  typedef struct {
    logic [5:0]  op;
    int unsigned delay;
    logic        z;
    logic [2:0]  exp_alu;
    int          kind;   // 0 = ALU/WB, 1 = branch, 2 = illegal
  } vec_t;

  vec_t tbl[10];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_req, input logic e_irw,
                          input logic e_pcw, input logic e_pcs, input logic [2:0] e_alu,
                          input logic e_src, input logic e_dst, input logic e_rw,
                          input logic e_ill);
    chk1({tag, "/imem_req"}, req, e_req);
    chk1({tag, "/ir_write"}, irw, e_irw);
    chk1({tag, "/pc_write"}, pcw, e_pcw);
    chk1({tag, "/pc_src"}, pcs, e_pcs);
    chk32({tag, "/ALUOp"}, 32'(alu), 32'(e_alu));
    chk1({tag, "/ALUSrc"}, src, e_src);
    chk1({tag, "/RegDst"}, dst, e_dst);
    chk1({tag, "/RegWrite"}, rw, e_rw);
    chk1({tag, "/illegal"}, ill, e_ill);
    chk1({tag, "/w4_RegWrite"}, q_rw, e_rw);
    chk32({tag, "/w4_ALUOp"}, 32'(q_alu), 32'(e_alu));
  endtask

  task automatic chk_ret(input string tag);
    chk32({tag, "/retired"}, retired, model_ret);
    chk32({tag, "/retired4"}, 32'(q_retired), model_ret % 16);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Reference classification straight from the opcode table.
  function automatic void ref_class(input logic [5:0] op, output logic [2:0] a, output int k);
    k = 0;
    a = 3'd0;
    case (op)
      6'b000000: a = 3'd0;
      6'b001000: a = 3'd1;
      6'b001011: a = 3'd2;
      6'b000100: begin a = 3'd3; k = 1; end
      6'b001111: a = 3'd4;
      6'b001101: a = 3'd5;
      6'b000101: begin a = 3'd6; k = 1; end
      default:   k = 2;
    endcase
  endfunction

  // Starts at posedge+1 in FETCH, ends at posedge+1 in FETCH (or after the illegal hold).
  task automatic run_instr(input string tag, input logic [5:0] op, input int unsigned delay,
                           input logic z, input logic [2:0] exp_alu, input int kind);
    logic tk;
    for (int i = 0; i <= int'(delay); i++) begin
      ack    = (i == int'(delay));
      opcode = 6'($urandom);
      zero   = 1'($urandom);
      #3;
      chk_outs({tag, "/fetch"}, 1'b1, ack, ack, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 0) chk_ret({tag, "/fetch"});
      next_cycle();
    end
    opcode = op;
    ack    = 1'($urandom);
    zero   = 1'($urandom);
    #3;
    chk_outs({tag, "/decode"}, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    opcode = 6'($urandom);
    ack    = 1'($urandom);
    if (kind == 0) begin
      #3;
      chk_outs({tag, "/exec"}, 1'b0, 1'b0, 1'b0, 1'b0, exp_alu, exp_alu != 3'd0,
               exp_alu == 3'd0, 1'b0, 1'b0);
      next_cycle();
      ack = 1'($urandom);
      #3;
      chk_outs({tag, "/wb"}, 1'b0, 1'b0, 1'b0, 1'b0, exp_alu, exp_alu != 3'd0,
               exp_alu == 3'd0, 1'b1, 1'b0);
      chk_ret({tag, "/wb"});
      next_cycle();
      model_ret++;
    end else if (kind == 1) begin
      zero = z;
      tk   = (op == 6'b000101) ? !z : z;
      #3;
      chk_outs({tag, "/branch"}, 1'b0, 1'b0, tk, tk, exp_alu, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
      model_ret++;
    end else begin
      for (int i = 0; i < 20; i++) begin
        ack = 1'($urandom);
        #3;
        chk1({tag, "/illegal"}, ill, 1'b1);
        chk1({tag, "/ill_req"}, req, 1'b0);
        chk1({tag, "/ill_irw"}, irw, 1'b0);
        chk1({tag, "/ill_pcw"}, pcw, 1'b0);
        chk1({tag, "/ill_rw"}, rw, 1'b0);
        chk_ret({tag, "/ill"});
        next_cycle();
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 in FETCH with the counter cleared.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_ret = 0;
    chk_outs({tag, "/in_reset"}, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ret({tag, "/in_reset"});
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    logic [5:0] op;
    logic [2:0] a;
    int         k;

    tbl[0] = '{op: 6'b001000, delay: 3, z: 1'b0, exp_alu: 3'd1, kind: 0};  // addi, slow ack
    tbl[1] = '{op: 6'b000000, delay: 0, z: 1'b0, exp_alu: 3'd0, kind: 0};  // R-type
    tbl[2] = '{op: 6'b000100, delay: 0, z: 1'b1, exp_alu: 3'd3, kind: 1};  // beq taken
    tbl[3] = '{op: 6'b000101, delay: 1, z: 1'b1, exp_alu: 3'd6, kind: 1};  // bne not taken
    tbl[4] = '{op: 6'b001011, delay: 2, z: 1'b0, exp_alu: 3'd2, kind: 0};  // sltiu
    tbl[5] = '{op: 6'b001111, delay: 0, z: 1'b1, exp_alu: 3'd4, kind: 0};  // lui
    tbl[6] = '{op: 6'b001101, delay: 1, z: 1'b0, exp_alu: 3'd5, kind: 0};  // ori
    tbl[7] = '{op: 6'b000100, delay: 0, z: 1'b0, exp_alu: 3'd3, kind: 1};  // beq not taken
    tbl[8] = '{op: 6'b000101, delay: 0, z: 1'b0, exp_alu: 3'd6, kind: 1};  // bne taken
    tbl[9] = '{op: 6'b000000, delay: 4, z: 1'b1, exp_alu: 3'd0, kind: 0};  // R-type, slow ack

    rst_n  = 1'b0;
    opcode = 6'd0;
    ack    = 1'b0;
    zero   = 1'b0;
    #3;
    chk_outs("por", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ret("por");
    next_cycle();
    #2;
    chk1("por_held/imem_req", req, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("post_reset/imem_req", req, 1'b1);
    next_cycle();

    for (int i = 0; i < 10; i++)
      run_instr($sformatf("vec%0d", i), tbl[i].op, tbl[i].delay, tbl[i].z, tbl[i].exp_alu,
                tbl[i].kind);
    chk_ret("after_vectors");

    // Reset pulsed mid-EXEC of ori: no WB pulse, counter cleared.
    ack    = 1'b1;
    #3;
    next_cycle();
    ack    = 1'b0;
    opcode = 6'b001101;
    next_cycle();
    #1;
    chk32("ori_exec/ALUOp", 32'(alu), 32'd5);
    rst_n = 1'b0;
    #1;
    model_ret = 0;
    chk_outs("rst_exec", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ret("rst_exec");
    next_cycle();
    #2;
    chk_outs("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("rst_release/imem_req", req, 1'b1);
    chk_ret("rst_release");
    next_cycle();

    // Randomized legal instruction stream against the reference classification.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 6))
          0: op = 6'b000000;
          1: op = 6'b001000;
          2: op = 6'b001011;
          3: op = 6'b000100;
          4: op = 6'b001111;
          5: op = 6'b001101;
          default: op = 6'b000101;
        endcase
      end else begin
        do begin
          op = 6'($urandom);
          ref_class(op, a, k);
        end while (k == 2);
      end
      ref_class(op, a, k);
      run_instr($sformatf("rnd%0d", i), op, $urandom_range(0, 3), 1'($urandom), a, k);
    end
    chk_ret("after_random");

    // 17 back-to-back lui on the 4-bit counter wraps to 1.
    do_reset("wrap_rst");
    for (int i = 0; i < 17; i++)
      run_instr($sformatf("lui%0d", i), 6'b001111, 0, 1'b0, 3'd4, 0);
    chk32("wrap/retired4", 32'(q_retired), 32'd1);
    chk32("wrap/retired32", retired, 32'd17);

    // Illegal opcode: terminal, counter frozen.
    run_instr("illegal", 6'b100011, 1, 1'b0, 3'd0, 2);
    rst_n = 1'b0;
    #1;
    chk1("illegal_reset/illegal", ill, 1'b0);
    chk1("illegal_reset/imem_req", req, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk1("illegal_exit/imem_req", req, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
